// File: rtl/lock_pkg.sv
// Shared definitions for the digital-lock sequencer: state encodings, blink types
// and the 12 MHz timing constants used as parameter defaults.
package lock_pkg;

  typedef enum logic [2:0] {
    ST_LOCKED,
    ST_CHECK,
    ST_UNLOCKED,
    ST_PROG,
    ST_BLINK_SETUP,
    ST_BLINK_REQ,
    ST_BLINK_RELEASE,
    ST_LOCKOUT
  } lock_state_e;

  localparam logic BLINK_ERROR = 1'b0;
  localparam logic BLINK_PROG  = 1'b1;

  localparam logic [31:0] CLK_HZ             = 32'd12000000;
  localparam logic [31:0] ENTRY_TIMEOUT_12M  = 32'd60000000;  // 5 s
  localparam logic [31:0] LOCKOUT_CYCLES_12M = 32'd120000000; // 10 s

endpackage

// File: rtl/lock_sequencer_if.sv
// Keypad/command inputs and the blinker request handshake of the lock sequencer.
// master = the sequencer, slave = keypad debouncer plus LED blinker side.
interface lock_sequencer_if #(
   parameter int DIGIT_W = 2
);
   logic               key_valid;
   logic [DIGIT_W-1:0] key_digit;
   logic               prog_req;
   logic               lock_req;
   logic               unlocked;
   logic               blink_type;
   logic               start_blinking;
   logic               done_blinking;
   logic [1:0]         fail_count;

   modport master (
      input  key_valid, key_digit, prog_req, lock_req, done_blinking,
      output unlocked, blink_type, start_blinking, fail_count
   );

   modport slave (
      output key_valid, key_digit, prog_req, lock_req, done_blinking,
      input  unlocked, blink_type, start_blinking, fail_count
   );
endinterface

// File: rtl/lock_sequencer_code_buffer.sv
// Digit collection buffer: shifts digits in MSB-first, counts them and stops at CODE_LEN.
// next_o is the value the buffer would hold after shifting in digit_i.
module code_buffer #(
   parameter int CODE_LEN = 4,
   parameter int DIGIT_W  = 2,
   parameter int CNT_W    = $clog2(CODE_LEN + 1)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         shift_i,
   input  logic                         clear_i,
   input  logic [DIGIT_W-1:0]           digit_i,
   output logic [CODE_LEN*DIGIT_W-1:0]  data_o,
   output logic [CODE_LEN*DIGIT_W-1:0]  next_o,
   output logic [CNT_W-1:0]             count_o,
   output logic                         last_o
);
   localparam int W = CODE_LEN * DIGIT_W;

   logic [W-1:0]     data_q, data_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full;

   assign full    = (count_q == CNT_W'(CODE_LEN));
   assign next_o  = (data_q << DIGIT_W) | W'(digit_i);
   assign data_o  = data_q;
   assign count_o = count_q;
   assign last_o  = (count_q == CNT_W'(CODE_LEN - 1));

   always_comb begin
      data_d  = data_q;
      count_d = count_q;
      // clear wins so the FSM can consume the final digit and empty the buffer together
      if (clear_i) begin
         data_d  = '0;
         count_d = '0;
      end else if (shift_i && !full) begin
         data_d  = next_o;
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         count_q <= '0;
      end else begin
         data_q  <= data_d;
         count_q <= count_d;
      end
   end
endmodule

// File: rtl/lock_sequencer.sv
// Digital-lock control FSM: code entry/check, code programming and blinker requests.
// Define LOCK_LOCKOUT_EN to add a timed LOCKOUT state after MAX_TRIES failures.
module lock_sequencer
   import lock_pkg::*;
#(
   parameter int                          CODE_LEN       = 4,
   parameter int                          DIGIT_W        = 2,
   parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE   = 8'b00011011,
   parameter int                          MAX_TRIES      = 3,
   parameter logic [31:0]                 ENTRY_TIMEOUT  = ENTRY_TIMEOUT_12M,
   parameter logic [31:0]                 LOCKOUT_CYCLES = LOCKOUT_CYCLES_12M
) (
   input logic              hwclk,
   input logic              rst,
   lock_sequencer_if.master bus
);
   localparam int          W         = CODE_LEN * DIGIT_W;
   localparam int          CNT_W     = $clog2(CODE_LEN + 1);
   localparam logic [1:0]  MAX_FAIL  = 2'(MAX_TRIES);
   localparam logic [31:0] TIMER_MAX = (ENTRY_TIMEOUT > LOCKOUT_CYCLES) ? ENTRY_TIMEOUT
                                                                        : LOCKOUT_CYCLES;

   lock_state_e state_q, state_d;
   logic        unlocked_q, unlocked_d;
   logic        start_q, start_d;
   logic        type_q, type_d;
   logic [1:0]  fail_q, fail_d;
   logic [W-1:0]  code_q, code_d;
   logic [31:0] timer_q, timer_d, timer_inc;

   logic             buf_shift, buf_clear, buf_last;
   logic [W-1:0]     buf_data, buf_next;
   logic [CNT_W-1:0] buf_count;

   code_buffer #(.CODE_LEN(CODE_LEN), .DIGIT_W(DIGIT_W), .CNT_W(CNT_W)) u_buf (
      .clk     (hwclk),
      .rst     (rst),
      .shift_i (buf_shift),
      .clear_i (buf_clear),
      .digit_i (bus.key_digit),
      .data_o  (buf_data),
      .next_o  (buf_next),
      .count_o (buf_count),
      .last_o  (buf_last)
   );

   assign timer_inc = (timer_q >= TIMER_MAX) ? timer_q : timer_q + 32'd1;

   always_comb begin
      state_d    = state_q;
      unlocked_d = unlocked_q;
      start_d    = start_q;
      type_d     = type_q;
      fail_d     = fail_q;
      code_d     = code_q;
      timer_d    = '0;
      buf_shift  = 1'b0;
      buf_clear  = 1'b0;
      case (state_q)
         ST_LOCKED: begin
            if (bus.key_valid) begin
               buf_shift = 1'b1;
               if (buf_last) state_d = ST_CHECK;
            end else if (buf_count != '0) begin
               if (timer_q >= ENTRY_TIMEOUT) buf_clear = 1'b1;
               else                          timer_d   = timer_inc;
            end
         end
         ST_CHECK: begin
            buf_clear = 1'b1;
            if (buf_data == code_q) begin
               state_d    = ST_UNLOCKED;
               unlocked_d = 1'b1;
               fail_d     = '0;
            end else begin
               fail_d  = (fail_q >= MAX_FAIL) ? fail_q : fail_q + 2'd1;
               type_d  = BLINK_ERROR;
               state_d = ST_BLINK_SETUP;
            end
         end
         ST_UNLOCKED: begin
            if (bus.lock_req) begin
               state_d    = ST_LOCKED;
               unlocked_d = 1'b0;
            end else if (bus.prog_req) begin
               state_d   = ST_PROG;
               buf_clear = 1'b1;
            end
         end
         ST_PROG: begin
            if (bus.lock_req) begin
               buf_clear  = 1'b1;
               state_d    = ST_LOCKED;
               unlocked_d = 1'b0;
            end else if (bus.key_valid) begin
               buf_shift = 1'b1;
               if (buf_last) begin
                  code_d    = buf_next;
                  buf_clear = 1'b1;
                  type_d    = BLINK_PROG;
                  state_d   = ST_BLINK_SETUP;
               end
            end else if (buf_count != '0) begin
               if (timer_q >= ENTRY_TIMEOUT) begin
                  buf_clear = 1'b1;
                  state_d   = ST_UNLOCKED;
               end else begin
                  timer_d = timer_inc;
               end
            end
         end
         // blink_type is already stable here; never raise a request over a stale done
         ST_BLINK_SETUP: begin
            if (!bus.done_blinking) begin
               start_d = 1'b1;
               state_d = ST_BLINK_REQ;
            end
         end
         ST_BLINK_REQ: begin
            if (bus.done_blinking) begin
               start_d = 1'b0;
               state_d = ST_BLINK_RELEASE;
            end
         end
         ST_BLINK_RELEASE: begin
            if (!bus.done_blinking) begin
               if (type_q == BLINK_PROG) begin
                  state_d = ST_UNLOCKED;
               end else begin
`ifdef LOCK_LOCKOUT_EN
                  state_d = (fail_q == MAX_FAIL) ? ST_LOCKOUT : ST_LOCKED;
`else
                  state_d = ST_LOCKED;
`endif
               end
            end
         end
`ifdef LOCK_LOCKOUT_EN
         ST_LOCKOUT: begin
            if (timer_q >= LOCKOUT_CYCLES) begin
               fail_d  = '0;
               state_d = ST_LOCKED;
            end else begin
               timer_d = timer_inc;
            end
         end
`endif
         default: begin
            state_d    = ST_LOCKED;
            unlocked_d = 1'b0;
            start_d    = 1'b0;
            buf_clear  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge hwclk) begin
      if (rst) begin
         state_q    <= ST_LOCKED;
         unlocked_q <= 1'b0;
         start_q    <= 1'b0;
         type_q     <= BLINK_ERROR;
         fail_q     <= '0;
         code_q     <= DEFAULT_CODE;
         timer_q    <= '0;
      end else begin
         state_q    <= state_d;
         unlocked_q <= unlocked_d;
         start_q    <= start_d;
         type_q     <= type_d;
         fail_q     <= fail_d;
         code_q     <= code_d;
         timer_q    <= timer_d;
      end
   end

   assign bus.unlocked       = unlocked_q;
   assign bus.start_blinking = start_q;
   assign bus.blink_type     = type_q;
   assign bus.fail_count     = fail_q;
endmodule
